imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 32-bit immediate value and an ImmSrc class, then produces the 24-bit instruction immediate field that the extender would expand back to exactly that value.
- Also flags whether the value is encodable for that class.
- Used by the assembler/loader path and the self-checking instruction generator that feed the ARM single-cycle and multi-cycle cores.
- Valid/ready handshake on input and output; a multi-cycle rotation search is available for DP immediates.

Parameters:
- DP, 2'b00: ImmSrc code for data-processing immediates.
- MEM, 2'b01: ImmSrc code for load/store offsets.
- B, 2'b10: ImmSrc code for branch offsets.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  Value/ImmSrc are valid.
- in_ready  output  1  encoder can accept a request; high only in IDLE.
- Value  input  32  immediate value to encode.
- ImmSrc  input  2  immediate class (DP/MEM/B; 2'b11 is illegal).
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts the result.
- Instr  output  24  encoded immediate field, Instr[23:0].
- ok  output  1  1 means Value is encodable and Instr is meaningful; 0 means Instr = 0.

Behaviour:
- States: IDLE, SEARCH, DONE.
- Reset (async, any state including mid-search): state = IDLE, out_valid = 0, Instr = 0, ok = 0, rotation counter = 0, latched Value/ImmSrc = 0.
- in_ready = (state == IDLE), generated combinationally.
- Accept: in_valid && in_ready at a rising edge latches Value and ImmSrc. in_valid is ignored outside IDLE.
- MEM: ok = (Value[31:12] == 0); Instr = {12'b0, Value[11:0]}. Go to DONE; out_valid is high the cycle after accept (latency 1).
- B: ok = (Value[1:0] == 0) && (Value[31:25] all equal); Instr = Value[25:2]. Latency 1.
- DP, macro absent: ok = (Value[31:8] == 0); Instr = {16'b0, Value[7:0]}. Latency 1.
- ImmSrc = 2'b11: ok = 0, Instr = 0. Latency 1.
- Whenever ok = 0, Instr is forced to 24'h0.
- DONE: out_valid = 1; Instr and ok are held stable until out_valid && out_ready at an edge, then the block returns to IDLE.
- No same-cycle accept on the DONE-to-IDLE edge. Maximum throughput is one request every 2 cycles (non-search path).
- out_ready is ignored when out_valid = 0.

Optional Feature:
- Macro: IMM_ENC_ROT_EN.
- Enabled: DP accept goes to SEARCH with counter r = 0.
  - Each SEARCH cycle tests rol(Value, 2r)[31:8] == 0.
  - On a match: Instr = {12'b0, r[3:0], rol(Value, 2r)[7:0]}, ok = 1, go to DONE. The smallest r always wins.
  - No match: r increments. If r = 15 fails: ok = 0, Instr = 0, go to DONE.
  - Latency from accept to out_valid is r + 2 cycles on success and 17 cycles on failure.
  - MEM, B and illegal paths are unchanged.
- Disabled: SEARCH is unreachable and DP follows the 8-bit zero-extend rule above.

Test Plan:
- MEM Value = 32'h0000_0ABC -> out_valid 1 cycle after accept; Instr = 24'h000ABC, ok = 1. MEM Value = 32'h0000_1000 -> ok = 0, Instr = 24'h000000.
- B Value = 32'hFFFF_FFF8 -> Instr = 24'hFFFFFE, ok = 1. B 32'h0200_0000 -> ok = 0. B 32'h0000_0006 -> ok = 0 (low bits set).
- DP Value = 32'h0000_00FF -> Instr = 24'h0000FF, ok = 1. DP 32'h0000_0100 with macro off -> ok = 0, latency 1.
- Macro on: DP 32'h0000_0100 -> Instr = 24'h000C01, ok = 1, out_valid 14 cycles after accept. DP 32'h0000_0101 -> ok = 0, Instr = 0, out_valid 17 cycles after accept.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> Instr/ok/out_valid stable, in_ready = 0, a new in_valid pulse is not accepted. Raise out_ready -> IDLE and in_ready = 1 on the next cycle.
- Reset mid-SEARCH (macro on, assert reset_n = 0 at r = 5) -> out_valid = 0, in_ready = 1 immediately. The next request encodes correctly from r = 0.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: turns a 32-bit value plus ImmSrc class back into the 24-bit instruction field.
// Define IMM_ENC_ROT_EN to enable the multi-cycle rotated-immediate search for DP values.
module imm_encoder #(
    parameter logic [1:0] DP  = 2'b00,
    parameter logic [1:0] MEM = 2'b01,
    parameter logic [1:0] B   = 2'b10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] Value,
    input  logic [1:0]  ImmSrc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] Instr,
    output logic        ok
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic [31:0] r_value;
    logic [1:0]  r_src;
    logic [24:0] w_direct;

`ifdef IMM_ENC_ROT_EN
    logic [3:0]  r_rot;
    logic        r_vld_p0;
    logic [31:0] r_cand_p0;
    logic [3:0]  r_rot_p0;
    logic [23:0] r_srch_instr;
    logic        r_srch_ok;
    logic        w_cand_hit;

    function automatic logic [31:0] rol2(input logic [31:0] v, input logic [3:0] r);
        logic [63:0] w_dbl;
        w_dbl = {v, v} << {r, 1'b0};
        return w_dbl[63:32];
    endfunction

    assign w_cand_hit = (r_cand_p0[31:8] == 24'h0);
`endif

    // Single-cycle encodings; result is {ok, Instr}, Instr forced to zero when not encodable.
    function automatic logic [24:0] enc_direct(input logic [31:0] v, input logic [1:0] src);
        logic [24:0] res;
        res = 25'h0;
        case (src)
            DP: begin
                if (v[31:8] == 24'h0)
                    res = {1'b1, 16'h0, v[7:0]};
            end
            MEM: begin
                if (v[31:12] == 20'h0)
                    res = {1'b1, 12'h0, v[11:0]};
            end
            B: begin
                if ((v[1:0] == 2'b00) && ((v[31:25] == 7'h00) || (v[31:25] == 7'h7F)))
                    res = {1'b1, v[25:2]};
            end
            default: res = 25'h0;
        endcase
        return res;
    endfunction

    assign w_direct = enc_direct(r_value, r_src);

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
`ifdef IMM_ENC_ROT_EN
                    w_next = (ImmSrc == DP) ? S_SEARCH : S_DONE;
`else
                    w_next = S_DONE;
`endif
                end
            end
            S_SEARCH: begin
`ifdef IMM_ENC_ROT_EN
                if (r_vld_p0 && (w_cand_hit || (r_rot_p0 == 4'hF)))
                    w_next = S_DONE;
`else
                w_next = S_IDLE;
`endif
            end
            S_DONE: begin
                if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= 32'h0;
            r_src   <= 2'b00;
        end else if (w_accept) begin
            r_value <= Value;
            r_src   <= ImmSrc;
        end
    end

`ifdef IMM_ENC_ROT_EN
    // Stage p0: one candidate rotation registered per cycle, tested the cycle after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rot        <= 4'h0;
            r_vld_p0     <= 1'b0;
            r_srch_ok    <= 1'b0;
            r_srch_instr <= 24'h0;
        end else if (w_accept) begin
            r_rot    <= 4'h0;
            r_vld_p0 <= 1'b0;
        end else if (r_state == S_SEARCH) begin
            r_rot    <= r_rot + 4'd1;
            r_vld_p0 <= 1'b1;
            if (w_next == S_DONE) begin
                r_vld_p0     <= 1'b0;
                r_srch_ok    <= w_cand_hit;
                r_srch_instr <= w_cand_hit ? {12'h0, r_rot_p0, r_cand_p0[7:0]} : 24'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_SEARCH) begin
            r_cand_p0 <= rol2(r_value, r_rot);
            r_rot_p0  <= r_rot;
        end
    end
`endif

    always_comb begin
        Instr = 24'h0;
        ok    = 1'b0;
        if (r_state == S_DONE) begin
`ifdef IMM_ENC_ROT_EN
            if (r_src == DP) begin
                Instr = r_srch_instr;
                ok    = r_srch_ok;
            end else
`endif
            begin
                Instr = w_direct[23:0];
                ok    = w_direct[24];
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed testbench for imm_encoder; expectations follow the build's IMM_ENC_ROT_EN setting.
module tb_imm_encoder;

    localparam logic [1:0] DP  = 2'b00;
    localparam logic [1:0] MEM = 2'b01;
    localparam logic [1:0] BR  = 2'b10;
`ifdef IMM_ENC_ROT_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] Value = 32'h0;
    logic [1:0]  ImmSrc = 2'b00;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [23:0] Instr;
    logic        ok;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_encoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .Value    (Value),
        .ImmSrc   (ImmSrc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Instr    (Instr),
        .ok       (ok)
    );

    task automatic accept(input logic [31:0] v, input logic [1:0] s);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        Value    = v;
        ImmSrc   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (Instr !== 24'h0) begin errors++; $display("FAIL reset_instr got %h want 000000", Instr); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL reset_ok got %b want 0", ok); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mem();
        logic [31:0] vals [3] = '{32'h0000_0ABC, 32'h0000_1000, 32'h0000_0FFF};
        logic [23:0] exp_i [3] = '{24'h000ABC, 24'h000000, 24'h000FFF};
        logic        exp_o [3] = '{1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            accept(vals[i], MEM);
            wait_valid(lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL mem_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (Instr !== exp_i[i]) begin errors++; $display("FAIL mem_instr[%0d] got %h want %h", i, Instr, exp_i[i]); end
            checks++; if (ok !== exp_o[i]) begin errors++; $display("FAIL mem_ok[%0d] got %b want %b", i, ok, exp_o[i]); end
            consume();
        end
    endtask

    task automatic test_branch();
        logic [31:0] vals [4] = '{32'hFFFF_FFF8, 32'h0200_0000, 32'h0000_0006, 32'h01FF_FFFC};
        logic [23:0] exp_i [4] = '{24'hFFFFFE, 24'h000000, 24'h000000, 24'h7FFFFF};
        logic        exp_o [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            accept(vals[i], BR);
            wait_valid(lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL b_latency[%0d] got %0d want 1", i, lat); end
            checks++; if (Instr !== exp_i[i]) begin errors++; $display("FAIL b_instr[%0d] got %h want %h", i, Instr, exp_i[i]); end
            checks++; if (ok !== exp_o[i]) begin errors++; $display("FAIL b_ok[%0d] got %b want %b", i, ok, exp_o[i]); end
            consume();
        end
    endtask

    task automatic test_dp();
        logic [31:0] vals [5] = '{32'h0000_00FF, 32'h0000_0000, 32'h0000_0100, 32'h0000_0101, 32'hFF00_0000};
        logic [23:0] exp_i [5];
        logic        exp_o [5];
        int          exp_l [5];
        int lat;
        exp_i = ROT ? '{24'h0000FF, 24'h000000, 24'h000C01, 24'h000000, 24'h0004FF}
                    : '{24'h0000FF, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
        exp_o = ROT ? '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1} : '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_l = ROT ? '{2, 2, 14, 17, 6} : '{1, 1, 1, 1, 1};
        for (int i = 0; i < 5; i++) begin
            accept(vals[i], DP);
            wait_valid(lat);
            checks++; if (lat !== exp_l[i]) begin errors++; $display("FAIL dp_latency[%0d] got %0d want %0d", i, lat, exp_l[i]); end
            checks++; if (Instr !== exp_i[i]) begin errors++; $display("FAIL dp_instr[%0d] got %h want %h", i, Instr, exp_i[i]); end
            checks++; if (ok !== exp_o[i]) begin errors++; $display("FAIL dp_ok[%0d] got %b want %b", i, ok, exp_o[i]); end
            consume();
        end
    endtask

    task automatic test_illegal();
        int lat;
        accept(32'h0000_0005, 2'b11);
        wait_valid(lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
        checks++; if (Instr !== 24'h0) begin errors++; $display("FAIL illegal_instr got %h want 000000", Instr); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL illegal_ok got %b want 0", ok); end
        consume();
    endtask

    task automatic test_backpressure();
        int lat;
        accept(32'h0000_0123, MEM);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                Value    = 32'h0000_0456;
                ImmSrc   = MEM;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got %b want 1", c, out_valid); end
            checks++; if (Instr !== 24'h000123) begin errors++; $display("FAIL bp_instr[%0d] got %h want 000123", c, Instr); end
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_ok[%0d] got %b want 1", c, ok); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); end
        end
        consume();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_pulse_dropped got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int lat;
        accept(32'h0000_0111, MEM);
        wait_valid(lat);
        @(negedge clk);
        out_ready = 1'b1;
        Value     = 32'h0000_0222;
        ImmSrc    = MEM;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_same_cycle got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", out_valid); end
        checks++; if (Instr !== 24'h000222) begin errors++; $display("FAIL b2b_second_instr got %h want 000222", Instr); end
        consume();
    endtask

    task automatic test_reset_mid();
        int lat;
        if (ROT) begin
            accept(32'h0000_0100, DP);
            repeat (5) @(posedge clk);
        end else begin
            accept(32'h0000_0ABC, MEM);
            wait_valid(lat);
        end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        checks++; if (Instr !== 24'h0) begin errors++; $display("FAIL rst_mid_instr got %h want 000000", Instr); end
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL rst_mid_ok got %b want 0", ok); end
        @(negedge clk);
        reset_n = 1'b1;
        accept(32'h0000_0100, DP);
        wait_valid(lat);
        checks++; if (lat !== (ROT ? 14 : 1)) begin errors++; $display("FAIL rst_after_latency got %0d want %0d", lat, ROT ? 14 : 1); end
        checks++; if (Instr !== (ROT ? 24'h000C01 : 24'h000000)) begin errors++; $display("FAIL rst_after_instr got %h want %h", Instr, ROT ? 24'h000C01 : 24'h000000); end
        checks++; if (ok !== ROT) begin errors++; $display("FAIL rst_after_ok got %b want %b", ok, ROT); end
        consume();
    endtask

    initial begin
        test_reset();
        test_mem();
        test_branch();
        test_dp();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
